accumulator_bank: RTL and testbench

Parametrised accumulator for the 8085 datapath. It holds the accumulator and carry flag and supports ALU and data-bus loads plus the rotate and complement ops (RLC, RRC, RAL, RAR, CMA). It adds a save/restore stack for interrupt context and gated, non-tri-state bus drive. It sits between the ALU output and the internal data bus mux.

---
 rtl/accumulator_bank.sv | 203 ++++++++++++++++++++
 tb/tb_accumulator_bank.sv | 196 +++++++++++++++++++
 2 files changed

// File: rtl/accumulator_bank.sv
// Accumulator and carry register with rotate/complement ops, a LIFO save stack
// for interrupt context and gated bus drive. Optional feature macro: ACC_PARITY_EN.
module accumulator_bank #(
  parameter  int WIDTH = 8,
  parameter  int DEPTH = 4,
  localparam int CNT_W = $clog2(DEPTH + 1)
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             op_valid,
  input  logic [2:0]       op,
  input  logic [WIDTH-1:0] alu_in,
  input  logic             alu_cy_in,
  input  logic [WIDTH-1:0] bus_in,
  input  logic             rd_en,
  input  logic             push,
  input  logic             pop,
  output logic [WIDTH-1:0] acc,
  output logic             cy,
  output logic             zero,
  output logic             parity,
  output logic [WIDTH-1:0] bus_out,
  output logic             bus_drive,
  output logic [CNT_W-1:0] depth_cnt,
  output logic             full,
  output logic             empty,
  output logic             ovf_err,
  output logic             unf_err
);

  // Stack storage is sized to the full index range so depth_cnt can address it directly.
  localparam int SLOTS = 1 << CNT_W;

  localparam logic [2:0] OP_NOP      = 3'd0;
  localparam logic [2:0] OP_LOAD_ALU = 3'd1;
  localparam logic [2:0] OP_LOAD_BUS = 3'd2;
  localparam logic [2:0] OP_RLC      = 3'd3;
  localparam logic [2:0] OP_RRC      = 3'd4;
  localparam logic [2:0] OP_RAL      = 3'd5;
  localparam logic [2:0] OP_RAR      = 3'd6;
  localparam logic [2:0] OP_CMA      = 3'd7;

  localparam logic [CNT_W-1:0] CNT_MAX  = CNT_W'(DEPTH);
  localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);
  localparam logic [CNT_W-1:0] CNT_ZERO = {CNT_W{1'b0}};

  logic [WIDTH-1:0] acc_r;
  logic [WIDTH-1:0] acc_op_s;
  logic [WIDTH-1:0] acc_nxt_s;
  logic             cy_r;
  logic             cy_op_s;
  logic             cy_nxt_s;
  logic [CNT_W-1:0] depth_r;
  logic [CNT_W-1:0] depth_nxt_s;
  logic [CNT_W-1:0] top_idx_s;
  logic [CNT_W-1:0] stack_wa_s;
  logic [WIDTH:0]   top_s;
  logic [WIDTH:0]   stack_r [SLOTS];
  logic             ovf_r;
  logic             unf_r;
  logic             ovf_nxt_s;
  logic             unf_nxt_s;
  logic             full_s;
  logic             empty_s;
  logic             exchange_s;
  logic             pop_s;
  logic             push_s;
  logic             op_exec_s;
  logic             stack_we_s;

  // Result of the requested datapath op computed from the registered acc/cy.
  always_comb begin
    acc_op_s = acc_r;
    cy_op_s  = cy_r;
    case (op)
      OP_NOP: begin
        acc_op_s = acc_r;
        cy_op_s  = cy_r;
      end
      OP_LOAD_ALU: begin
        acc_op_s = alu_in;
        cy_op_s  = alu_cy_in;
      end
      OP_LOAD_BUS: begin
        acc_op_s = bus_in;
      end
      OP_RLC: begin
        acc_op_s = {acc_r[WIDTH-2:0], acc_r[WIDTH-1]};
        cy_op_s  = acc_r[WIDTH-1];
      end
      OP_RRC: begin
        acc_op_s = {acc_r[0], acc_r[WIDTH-1:1]};
        cy_op_s  = acc_r[0];
      end
      OP_RAL: begin
        acc_op_s = {acc_r[WIDTH-2:0], cy_r};
        cy_op_s  = acc_r[WIDTH-1];
      end
      OP_RAR: begin
        acc_op_s = {cy_r, acc_r[WIDTH-1:1]};
        cy_op_s  = acc_r[0];
      end
      OP_CMA: begin
        acc_op_s = ~acc_r;
      end
      default: begin
        acc_op_s = acc_r;
        cy_op_s  = cy_r;
      end
    endcase
  end

  // Stack control: push+pop on an empty stack degrades to a plain push, and
  // any effective pop (restore, exchange or rejected pop) discards the op.
  always_comb begin
    full_s     = (depth_r == CNT_MAX);
    empty_s    = (depth_r == CNT_ZERO);
    top_idx_s  = depth_r - CNT_ONE;
    top_s      = stack_r[top_idx_s];
    exchange_s = push & pop & ~empty_s;
    pop_s      = pop & ~push & ~empty_s;
    push_s     = push & (~pop | empty_s) & ~full_s;
    op_exec_s  = op_valid & (~pop | (push & empty_s));
    ovf_nxt_s  = push & (~pop | empty_s) & full_s;
    unf_nxt_s  = pop & ~push & empty_s;
  end

  // Next-state selection for acc/cy, stack pointer and stack write port.
  always_comb begin
    acc_nxt_s   = acc_r;
    cy_nxt_s    = cy_r;
    depth_nxt_s = depth_r;
    stack_we_s  = push_s | exchange_s;
    stack_wa_s  = top_idx_s;

    if (exchange_s || pop_s) begin
      {cy_nxt_s, acc_nxt_s} = top_s;
    end else if (op_exec_s) begin
      acc_nxt_s = acc_op_s;
      cy_nxt_s  = cy_op_s;
    end else begin
      acc_nxt_s = acc_r;
      cy_nxt_s  = cy_r;
    end

    if (push_s) begin
      depth_nxt_s = depth_r + CNT_ONE;
      stack_wa_s  = depth_r;
    end else if (pop_s) begin
      depth_nxt_s = depth_r - CNT_ONE;
      stack_wa_s  = top_idx_s;
    end else begin
      depth_nxt_s = depth_r;
      stack_wa_s  = top_idx_s;
    end
  end

  // Architectural state and error pulses; reset wins over every other input.
  always_ff @(posedge clk) begin
    if (rst) begin
      acc_r   <= {WIDTH{1'b0}};
      cy_r    <= 1'b0;
      depth_r <= CNT_ZERO;
      ovf_r   <= 1'b0;
      unf_r   <= 1'b0;
    end else begin
      acc_r   <= acc_nxt_s;
      cy_r    <= cy_nxt_s;
      depth_r <= depth_nxt_s;
      ovf_r   <= ovf_nxt_s;
      unf_r   <= unf_nxt_s;
    end
  end

  // Stack storage; contents are meaningless after reset so it carries no reset.
  always_ff @(posedge clk) begin
    if (stack_we_s && !rst) begin
      stack_r[stack_wa_s] <= {cy_r, acc_r};
    end
  end

`ifdef ACC_PARITY_EN
  function automatic logic even_parity(input logic [WIDTH-1:0] value);
    return ~^value;
  endfunction

  assign parity = even_parity(acc_r);
`else
  assign parity = 1'b0;
`endif

  assign acc       = acc_r;
  assign cy        = cy_r;
  assign zero      = (acc_r == {WIDTH{1'b0}});
  assign bus_out   = rd_en ? acc_r : {WIDTH{1'b0}};
  assign bus_drive = rd_en;
  assign depth_cnt = depth_r;
  assign full      = (depth_r == CNT_MAX);
  assign empty     = (depth_r == CNT_ZERO);
  assign ovf_err   = ovf_r;
  assign unf_err   = unf_r;

endmodule

// File: tb/tb_accumulator_bank.sv
// Directed table-driven bench for accumulator_bank (WIDTH=8, DEPTH=4), plus
// hand-written bus-drive checks.
module tb_accumulator_bank;

  localparam int W  = 8;
  localparam int D  = 4;
  localparam int CW = 3;

  localparam logic [2:0] N   = 3'd0;
  localparam logic [2:0] LA  = 3'd1;
  localparam logic [2:0] LB  = 3'd2;
  localparam logic [2:0] RLC = 3'd3;
  localparam logic [2:0] RRC = 3'd4;
  localparam logic [2:0] RAL = 3'd5;
  localparam logic [2:0] RAR = 3'd6;
  localparam logic [2:0] CMA = 3'd7;

  logic          clk;
  logic          rst;
  logic          op_valid;
  logic [2:0]    op;
  logic [W-1:0]  alu_in;
  logic          alu_cy_in;
  logic [W-1:0]  bus_in;
  logic          rd_en;
  logic          push;
  logic          pop;
  logic [W-1:0]  acc;
  logic          cy;
  logic          zero;
  logic          parity;
  logic [W-1:0]  bus_out;
  logic          bus_drive;
  logic [CW-1:0] depth_cnt;
  logic          full;
  logic          empty;
  logic          ovf_err;
  logic          unf_err;

  accumulator_bank #(.WIDTH(W), .DEPTH(D)) dut (
    .clk(clk), .rst(rst), .op_valid(op_valid), .op(op), .alu_in(alu_in),
    .alu_cy_in(alu_cy_in), .bus_in(bus_in), .rd_en(rd_en), .push(push), .pop(pop),
    .acc(acc), .cy(cy), .zero(zero), .parity(parity), .bus_out(bus_out),
    .bus_drive(bus_drive), .depth_cnt(depth_cnt), .full(full), .empty(empty),
    .ovf_err(ovf_err), .unf_err(unf_err)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic          r;
    logic          v;
    logic [2:0]    o;
    logic [W-1:0]  alu;
    logic          acy;
    logic [W-1:0]  bus;
    logic          psh;
    logic          pp;
    logic [W-1:0]  e_acc;
    logic          e_cy;
    logic [CW-1:0] e_depth;
    logic          e_ovf;
    logic          e_unf;
  } vec_t;

  vec_t vt[$];
  int   checks = 0;
  int   passes = 0;

  function automatic vec_t mk(input logic r, input logic v, input logic [2:0] o,
                              input logic [W-1:0] alu, input logic acy, input logic [W-1:0] bus,
                              input logic psh, input logic pp, input logic [W-1:0] e_acc,
                              input logic e_cy, input logic [CW-1:0] e_depth,
                              input logic e_ovf, input logic e_unf);
    vec_t t;
    t.r = r; t.v = v; t.o = o; t.alu = alu; t.acy = acy; t.bus = bus;
    t.psh = psh; t.pp = pp; t.e_acc = e_acc; t.e_cy = e_cy;
    t.e_depth = e_depth; t.e_ovf = e_ovf; t.e_unf = e_unf;
    return t;
  endfunction

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act === exp) passes++;
    else $display("FAIL %s: got %h expected %h", name, act, exp);
  endtask

  // Expected flag word {acc,cy,zero,parity,depth,full,empty,ovf,unf} built from a row.
  function automatic logic [31:0] expect_word(input vec_t t);
    logic ep;
`ifdef ACC_PARITY_EN
    ep = ~^t.e_acc;
`else
    ep = 1'b0;
`endif
    return {14'd0, t.e_acc, t.e_cy, (t.e_acc == 8'h00), ep, t.e_depth,
            (t.e_depth == 3'd4), (t.e_depth == 3'd0), t.e_ovf, t.e_unf};
  endfunction

  function automatic logic [31:0] actual_word();
    return {14'd0, acc, cy, zero, parity, depth_cnt, full, empty, ovf_err, unf_err};
  endfunction

  task automatic apply(input vec_t t);
    @(negedge clk);
    rst = t.r; op_valid = t.v; op = t.o; alu_in = t.alu; alu_cy_in = t.acy;
    bus_in = t.bus; push = t.psh; pop = t.pp; rd_en = 1'b0;
    @(posedge clk);
    #1;
  endtask

  initial begin
    string nm;
    rst = 1'b1; op_valid = 1'b0; op = N; alu_in = 8'h00; alu_cy_in = 1'b0;
    bus_in = 8'h00; rd_en = 1'b0; push = 1'b0; pop = 1'b0;

    //          r     v     op   alu    acy   bus    psh   pop   acc    cy    dep   ovf   unf
    vt.push_back(mk(1'b1, 1'b1, LA,  8'h5A, 1'b1, 8'h00, 1'b1, 1'b0, 8'h00, 1'b0, 3'd0, 1'b0, 1'b0));
    vt.push_back(mk(1'b0, 1'b1, LA,  8'h00, 1'b1, 8'h00, 1'b0, 1'b0, 8'h00, 1'b1, 3'd0, 1'b0, 1'b0));
    vt.push_back(mk(1'b0, 1'b1, LB,  8'h00, 1'b0, 8'h96, 1'b0, 1'b0, 8'h96, 1'b1, 3'd0, 1'b0, 1'b0));
    vt.push_back(mk(1'b0, 1'b1, RLC, 8'h00, 1'b0, 8'h00, 1'b0, 1'b0, 8'h2D, 1'b1, 3'd0, 1'b0, 1'b0));
    vt.push_back(mk(1'b0, 1'b1, RAR, 8'h00, 1'b0, 8'h00, 1'b0, 1'b0, 8'h96, 1'b1, 3'd0, 1'b0, 1'b0));
    vt.push_back(mk(1'b0, 1'b1, CMA, 8'h00, 1'b0, 8'h00, 1'b0, 1'b0, 8'h69, 1'b1, 3'd0, 1'b0, 1'b0));
    vt.push_back(mk(1'b0, 1'b1, RRC, 8'h00, 1'b0, 8'h00, 1'b0, 1'b0, 8'hB4, 1'b1, 3'd0, 1'b0, 1'b0));
    vt.push_back(mk(1'b0, 1'b1, RAL, 8'h00, 1'b0, 8'h00, 1'b0, 1'b0, 8'h69, 1'b1, 3'd0, 1'b0, 1'b0));
    vt.push_back(mk(1'b0, 1'b0, CMA, 8'h00, 1'b0, 8'h00, 1'b0, 1'b0, 8'h69, 1'b1, 3'd0, 1'b0, 1'b0));
    vt.push_back(mk(1'b0, 1'b1, N,   8'h00, 1'b0, 8'h00, 1'b0, 1'b0, 8'h69, 1'b1, 3'd0, 1'b0, 1'b0));
    vt.push_back(mk(1'b0, 1'b1, LA,  8'h12, 1'b0, 8'h00, 1'b0, 1'b0, 8'h12, 1'b0, 3'd0, 1'b0, 1'b0));
    vt.push_back(mk(1'b0, 1'b1, RAR, 8'h00, 1'b0, 8'h00, 1'b0, 1'b0, 8'h09, 1'b0, 3'd0, 1'b0, 1'b0));
    vt.push_back(mk(1'b0, 1'b1, RAL, 8'h00, 1'b0, 8'h00, 1'b0, 1'b0, 8'h12, 1'b0, 3'd0, 1'b0, 1'b0));
    // Fill the stack with 01..04, fifth push is rejected while its op runs.
    vt.push_back(mk(1'b0, 1'b1, LA,  8'h01, 1'b0, 8'h00, 1'b0, 1'b0, 8'h01, 1'b0, 3'd0, 1'b0, 1'b0));
    vt.push_back(mk(1'b0, 1'b0, N,   8'h00, 1'b0, 8'h00, 1'b1, 1'b0, 8'h01, 1'b0, 3'd1, 1'b0, 1'b0));
    vt.push_back(mk(1'b0, 1'b1, LA,  8'h02, 1'b0, 8'h00, 1'b0, 1'b0, 8'h02, 1'b0, 3'd1, 1'b0, 1'b0));
    vt.push_back(mk(1'b0, 1'b0, N,   8'h00, 1'b0, 8'h00, 1'b1, 1'b0, 8'h02, 1'b0, 3'd2, 1'b0, 1'b0));
    vt.push_back(mk(1'b0, 1'b1, LA,  8'h03, 1'b0, 8'h00, 1'b0, 1'b0, 8'h03, 1'b0, 3'd2, 1'b0, 1'b0));
    vt.push_back(mk(1'b0, 1'b0, N,   8'h00, 1'b0, 8'h00, 1'b1, 1'b0, 8'h03, 1'b0, 3'd3, 1'b0, 1'b0));
    vt.push_back(mk(1'b0, 1'b1, LA,  8'h04, 1'b0, 8'h00, 1'b0, 1'b0, 8'h04, 1'b0, 3'd3, 1'b0, 1'b0));
    vt.push_back(mk(1'b0, 1'b0, N,   8'h00, 1'b0, 8'h00, 1'b1, 1'b0, 8'h04, 1'b0, 3'd4, 1'b0, 1'b0));
    vt.push_back(mk(1'b0, 1'b1, LA,  8'h05, 1'b1, 8'h00, 1'b1, 1'b0, 8'h05, 1'b1, 3'd4, 1'b1, 1'b0));
    vt.push_back(mk(1'b0, 1'b0, N,   8'h00, 1'b0, 8'h00, 1'b0, 1'b0, 8'h05, 1'b1, 3'd4, 1'b0, 1'b0));
    vt.push_back(mk(1'b0, 1'b0, N,   8'h00, 1'b0, 8'h00, 1'b0, 1'b1, 8'h04, 1'b0, 3'd3, 1'b0, 1'b0));
    vt.push_back(mk(1'b0, 1'b0, N,   8'h00, 1'b0, 8'h00, 1'b0, 1'b1, 8'h03, 1'b0, 3'd2, 1'b0, 1'b0));
    vt.push_back(mk(1'b0, 1'b0, N,   8'h00, 1'b0, 8'h00, 1'b0, 1'b1, 8'h02, 1'b0, 3'd1, 1'b0, 1'b0));
    vt.push_back(mk(1'b0, 1'b0, N,   8'h00, 1'b0, 8'h00, 1'b0, 1'b1, 8'h01, 1'b0, 3'd0, 1'b0, 1'b0));
    vt.push_back(mk(1'b0, 1'b1, CMA, 8'h00, 1'b0, 8'h00, 1'b0, 1'b1, 8'h01, 1'b0, 3'd0, 1'b0, 1'b1));
    vt.push_back(mk(1'b0, 1'b0, N,   8'h00, 1'b0, 8'h00, 1'b0, 1'b0, 8'h01, 1'b0, 3'd0, 1'b0, 1'b0));
    // Exchange: top {0,AA} swaps with {1,11}; the following pop proves the new top.
    vt.push_back(mk(1'b0, 1'b1, LA,  8'hAA, 1'b0, 8'h00, 1'b0, 1'b0, 8'hAA, 1'b0, 3'd0, 1'b0, 1'b0));
    vt.push_back(mk(1'b0, 1'b0, N,   8'h00, 1'b0, 8'h00, 1'b1, 1'b0, 8'hAA, 1'b0, 3'd1, 1'b0, 1'b0));
    vt.push_back(mk(1'b0, 1'b1, LA,  8'h11, 1'b1, 8'h00, 1'b0, 1'b0, 8'h11, 1'b1, 3'd1, 1'b0, 1'b0));
    vt.push_back(mk(1'b0, 1'b1, CMA, 8'h00, 1'b0, 8'h00, 1'b1, 1'b1, 8'hAA, 1'b0, 3'd1, 1'b0, 1'b0));
    vt.push_back(mk(1'b0, 1'b0, N,   8'h00, 1'b0, 8'h00, 1'b0, 1'b1, 8'h11, 1'b1, 3'd0, 1'b0, 1'b0));
    // Pop discards a same-cycle LOAD_BUS.
    vt.push_back(mk(1'b0, 1'b1, LA,  8'h33, 1'b0, 8'h00, 1'b0, 1'b0, 8'h33, 1'b0, 3'd0, 1'b0, 1'b0));
    vt.push_back(mk(1'b0, 1'b0, N,   8'h00, 1'b0, 8'h00, 1'b1, 1'b0, 8'h33, 1'b0, 3'd1, 1'b0, 1'b0));
    vt.push_back(mk(1'b0, 1'b1, LA,  8'h44, 1'b1, 8'h00, 1'b0, 1'b0, 8'h44, 1'b1, 3'd1, 1'b0, 1'b0));
    vt.push_back(mk(1'b0, 1'b1, LB,  8'h00, 1'b0, 8'hFF, 1'b0, 1'b1, 8'h33, 1'b0, 3'd0, 1'b0, 1'b0));
    // Push+pop on empty acts as push and the op runs.
    vt.push_back(mk(1'b0, 1'b1, LB,  8'h00, 1'b0, 8'h77, 1'b1, 1'b1, 8'h77, 1'b0, 3'd1, 1'b0, 1'b0));
    // Reset with push: stack is discarded, later pop underflows.
    vt.push_back(mk(1'b1, 1'b1, LB,  8'h00, 1'b0, 8'hEE, 1'b1, 1'b0, 8'h00, 1'b0, 3'd0, 1'b0, 1'b0));
    vt.push_back(mk(1'b0, 1'b0, N,   8'h00, 1'b0, 8'h00, 1'b0, 1'b1, 8'h00, 1'b0, 3'd0, 1'b0, 1'b1));
    vt.push_back(mk(1'b0, 1'b1, LA,  8'h5C, 1'b1, 8'h00, 1'b1, 1'b0, 8'h5C, 1'b1, 3'd1, 1'b0, 1'b0));
    vt.push_back(mk(1'b0, 1'b0, N,   8'h00, 1'b0, 8'h00, 1'b0, 1'b1, 8'h00, 1'b0, 3'd0, 1'b0, 1'b0));
    vt.push_back(mk(1'b0, 1'b1, LB,  8'h00, 1'b0, 8'h5A, 1'b0, 1'b0, 8'h5A, 1'b0, 3'd0, 1'b0, 1'b0));

    for (int i = 0; i < vt.size(); i++) begin
      apply(vt[i]);
      nm = $sformatf("row%0d", i);
      check(nm, actual_word(), expect_word(vt[i]));
    end

    // Bus drive follows rd_en with no clock edge in between (acc is 5A).
    @(negedge clk);
    op_valid = 1'b0; push = 1'b0; pop = 1'b0;
    rd_en = 1'b1;
    #1;
    check("bus_on", {23'd0, bus_drive, bus_out}, {23'd0, 1'b1, 8'h5A});
    rd_en = 1'b0;
    #1;
    check("bus_off", {23'd0, bus_drive, bus_out}, {23'd0, 1'b0, 8'h00});
    @(negedge clk);
    op_valid = 1'b1; op = CMA; rd_en = 1'b1;
    @(posedge clk);
    #1;
    check("bus_after_cma", {23'd0, bus_drive, bus_out}, {23'd0, 1'b1, 8'hA5});
    @(negedge clk);
    op_valid = 1'b0; rd_en = 1'b0;

    $display("%0d/%0d checks passed", passes, checks);
    $finish;
  end

endmodule
